// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive controller driven by a 16x oversampling tick.
// Samples each bit once at mid-bit and reports bytes or framing errors with 1-clk strobes.
module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_vld,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] dout_d;
  logic                 vld_d, ferr_d;
  logic                 rxd_m, rxd_s;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rxd_m     <= 1'b1;
      rxd_s     <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rxd_m     <= rxd;
      rxd_s     <= rxd_m;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      dout      <= dout_d;
      dout_vld  <= vld_d;
      frame_err <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    dout_d  = dout;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            cnt_d   = '0;
            state_d = START;
          end
        end
        START: begin
          cnt_d = cnt_q + 1'b1;
          // Mid start bit: confirm the line is still low, else treat as noise.
          if (cnt_q == HALF_M1) begin
            if (!rxd_s) begin
              cnt_d   = '0;
              bit_d   = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == FULL_M1) begin
            sh_d  = {rxd_s, sh_q[DATA_BITS-1:1]};
            cnt_d = '0;
            bit_d = bit_q + 1'b1;
            if (bit_q == LAST_BIT) state_d = STOP;
          end
        end
        STOP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == FULL_M1) begin
            cnt_d = '0;
            if (rxd_s) begin
              dout_d  = sh_q;
              vld_d   = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end
        end
        BREAK: begin
          // Wait for the line to go idle so a held-low line cannot restart a frame.
          if (rxd_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a table of single frames plus
// hand-written back-to-back, false-start, break, reset and glitch sequences.
module tb_uart_rx_ctrl;
  localparam int CPB = 64;  // clk per bit: tick every 4 clk, 16 ticks per bit

  logic       clk, rstn, tick, rxd;
  logic [7:0] dout;
  logic       dout_vld, frame_err, busy;

  int passed = 0;
  int total  = 0;

  // monitor state, written only by the monitor process
  int         vld_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         busy_cnt = 0;
  logic [7:0] dq[$];

  uart_rx_ctrl #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk), .rstn(rstn), .tick(tick), .rxd(rxd),
    .dout(dout), .dout_vld(dout_vld), .frame_err(frame_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int tph;
    tph  = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (tph == 0);
      tph  = (tph + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (dout_vld) begin
      vld_cnt = vld_cnt + 1;
      dq.push_back(dout);
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (dout_vld && frame_err) both_cnt = both_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic send_bit(input logic b, input bit g_early, input bit g_late);
    for (int i = 0; i < CPB; i++) begin
      rxd = ((g_early && i == 12) || (g_late && i == 52)) ? ~b : b;
      @(negedge clk);
    end
    rxd = b;
  endtask

  // Leaves rxd at the stop level; caller decides what the line does next.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit glitch);
    send_bit(1'b0, 1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch, glitch);
    send_bit(stop, glitch, 1'b0);
  endtask

  task automatic idle(input int clks);
    rxd = 1'b1;
    repeat (clks) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_dout;
    int         exp_vld;
    int         exp_ferr;
  } vec_t;

  initial begin
    vec_t vt[5];
    int   v0, f0, b0, bz0, q0;

    vt[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    vt[1] = '{8'h3C, 1'b0, 8'hA5, 0, 1};
    vt[2] = '{8'h5A, 1'b1, 8'h5A, 1, 0};
    vt[3] = '{8'h01, 1'b1, 8'h01, 1, 0};
    vt[4] = '{8'h80, 1'b1, 8'h80, 1, 0};

    rstn = 1'b0;
    rxd  = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_dout", dout, 8'h00);
    chk("rst_vld", dout_vld, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);
    rstn = 1'b1;
    idle(CPB);

    for (int k = 0; k < 5; k++) begin
      v0 = vld_cnt; f0 = ferr_cnt; b0 = both_cnt;
      send_frame(vt[k].data, vt[k].stop, 1'b0);
      idle(2 * CPB);
      chk($sformatf("vec%0d_vld", k), vld_cnt - v0, vt[k].exp_vld);
      chk($sformatf("vec%0d_ferr", k), ferr_cnt - f0, vt[k].exp_ferr);
      chk($sformatf("vec%0d_dout", k), dout, vt[k].exp_dout);
      chk($sformatf("vec%0d_busy", k), busy, 0);
      chk($sformatf("vec%0d_both", k), both_cnt - b0, 0);
    end

    // back-to-back 0x00 then 0xFF, no idle gap
    v0 = vld_cnt; q0 = dq.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(2 * CPB);
    chk("b2b_vld", vld_cnt - v0, 2);
    chk("b2b_first", (dq.size() > q0) ? dq[q0] : 8'hxx, 8'h00);
    chk("b2b_second", (dq.size() > q0 + 1) ? dq[q0+1] : 8'hxx, 8'hFF);

    // 3-tick low pulse: false start
    v0 = vld_cnt; f0 = ferr_cnt; bz0 = busy_cnt;
    rxd = 1'b0;
    repeat (12) @(negedge clk);
    idle(200);
    chk("fs_busy_seen", (busy_cnt - bz0) > 0, 1);
    chk("fs_busy", busy, 0);
    chk("fs_vld", vld_cnt - v0, 0);
    chk("fs_ferr", ferr_cnt - f0, 0);
    chk("fs_dout", dout, 8'hFF);

    // stop bit low, line held low 40 ticks, then recovery frame
    v0 = vld_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (160) @(negedge clk);
    chk("brk_ferr", ferr_cnt - f0, 1);
    chk("brk_vld", vld_cnt - v0, 0);
    chk("brk_busy_held", busy, 1);
    chk("brk_dout", dout, 8'hFF);
    idle(CPB);
    chk("brk_busy_exit", busy, 0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(2 * CPB);
    chk("brk_next_vld", vld_cnt - v0, 1);
    chk("brk_next_dout", dout, 8'h81);

    // reset mid data bit 4 of 0x5A
    v0 = vld_cnt; f0 = ferr_cnt;
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i), 1'b0, 1'b0);
    rxd = 1'b1;  // bit 4 of 0x5A
    repeat (CPB / 2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("mrst_dout", dout, 8'h00);
    chk("mrst_busy", busy, 0);
    chk("mrst_vld", dout_vld, 0);
    chk("mrst_ferr", frame_err, 0);
    rstn = 1'b1;
    idle(10 * CPB);
    chk("mrst_nostrobe", (vld_cnt - v0) + (ferr_cnt - f0), 0);
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(2 * CPB);
    chk("mrst_next_vld", vld_cnt - v0, 1);
    chk("mrst_next_dout", dout, 8'hC3);

    // 1-clk glitches away from the sample points
    v0 = vld_cnt; f0 = ferr_cnt;
    send_frame(8'h96, 1'b1, 1'b1);
    idle(2 * CPB);
    chk("glitch_vld", vld_cnt - v0, 1);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    chk("glitch_dout", dout, 8'h96);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
